// File: rtl/mem_bus_responder.sv
// Byte-wide memory bus responder: main RAM plus a small I/O window
// (UART TX FIFO / RX byte, free-running cycle counter, program stop).
module mem_bus_responder #(
    parameter int unsigned ADDR_WIDTH    = 17,
    parameter int unsigned TX_FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_done
);

    localparam int unsigned RAM_BYTES = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W     = $clog2(TX_FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    localparam logic [15:0] IO_UART  = 16'h0000;
    localparam logic [15:0] IO_CLK0  = 16'h0004;
    localparam logic [15:0] IO_CLK1  = 16'h0005;
    localparam logic [15:0] IO_CLK2  = 16'h0006;
    localparam logic [15:0] IO_CLK3  = 16'h0007;

    logic [7:0]            r_ram [RAM_BYTES];
    logic [7:0]            r_fifo [TX_FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [31:0]           r_cyc;
    logic [31:0]           r_snap;
    logic [7:0]            r_mem_din;
    logic                  r_rx_ready;
    logic                  r_done;
    logic                  r_full;

    logic                  w_io;
    logic [15:0]           w_sub;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_ram_we;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_pop;
    logic [7:0]            w_push_data;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [7:0]            w_rd_data;
    logic                  w_rx_pop;
    logic                  w_unused_addr;

    assign w_io          = (mem_a[17:16] == 2'b11);
    assign w_sub         = mem_a[15:0];
    assign w_ram_idx     = mem_a[ADDR_WIDTH-1:0];
    assign w_unused_addr = &{1'b0, mem_a[31:18]};

    assign w_ram_we    = rdy_in & mem_wr & ~w_io;
    // The stop write pushes a 0x00 terminator that bypasses the zero filter.
    assign w_push_req  = rdy_in & mem_wr & w_io &
                         (((w_sub == IO_UART) && (mem_dout != 8'h00)) || (w_sub == IO_CLK0));
    assign w_push_data = (w_sub == IO_CLK0) ? 8'h00 : mem_dout;
    assign w_pop       = rdy_in & tx_ready & (r_count != CNT_W'(0));
    assign w_push      = w_push_req & ((r_count != CNT_W'(TX_FIFO_DEPTH)) | w_pop);
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Read-data select for the response registered at the next edge.
    always_comb begin
        w_rd_data = 8'h00;
        w_rx_pop  = 1'b0;
        if (!w_io) begin
            w_rd_data = r_ram[w_ram_idx];
        end else begin
            case (w_sub)
                IO_UART: begin
                    if (rx_valid) begin
                        w_rd_data = rx_data;
                        w_rx_pop  = 1'b1;
                    end
                end
                IO_CLK0: w_rd_data = r_cyc[7:0];
                IO_CLK1: w_rd_data = r_snap[15:8];
                IO_CLK2: w_rd_data = r_snap[23:16];
                IO_CLK3: w_rd_data = r_snap[31:24];
                default: w_rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_data;
        end
    end

    // Control state: response, counter, FIFO bookkeeping, stop flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_mem_din  <= 8'h00;
            r_rx_ready <= 1'b0;
            r_done     <= 1'b0;
            r_full     <= 1'b0;
            r_cyc      <= 32'h0000_0000;
            r_snap     <= 32'h0000_0000;
            r_wr_ptr   <= PTR_W'(0);
            r_rd_ptr   <= PTR_W'(0);
            r_count    <= CNT_W'(0);
        end else if (!rdy_in) begin
            r_rx_ready <= 1'b0;
        end else begin
            r_cyc      <= r_cyc + 32'd1;
            r_rx_ready <= 1'b0;
            if (!mem_wr) begin
                r_mem_din  <= w_rd_data;
                r_rx_ready <= w_rx_pop;
                if (w_io && (w_sub == IO_CLK0)) begin
                    r_snap <= r_cyc;
                end
            end else if (w_io && (w_sub == IO_CLK0)) begin
                r_done <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt >= CNT_W'(TX_FIFO_DEPTH - 1));
        end
    end

    assign mem_din        = r_mem_din;
    assign rx_ready       = r_rx_ready;
    assign program_done   = r_done;
    assign io_buffer_full = r_full;
    assign tx_valid       = (r_count != CNT_W'(0));
    assign tx_data        = r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: random bus traffic checked against a
// queue/array reference model of the RAM, TX FIFO, RX port and counter.
module tb_mem_bus_responder;

    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_done;

    mem_bus_responder #(.ADDR_WIDTH(17), .TX_FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_done(program_done)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic [7:0]  m_ram [int];
    logic [7:0]  m_tx [$];
    logic [7:0]  m_drained [$];
    logic [7:0]  d_drained [$];
    logic [31:0] m_cyc;
    logic [31:0] m_snap;
    logic [7:0]  m_din;
    logic        m_rx_ready;
    logic        m_done;
    logic        m_full;

    task automatic model_reset();
        m_tx.delete();
        m_cyc      = 32'h0;
        m_snap     = 32'h0;
        m_din      = 8'h00;
        m_rx_ready = 1'b0;
        m_done     = 1'b0;
        m_full     = 1'b0;
    endtask

    // One bus cycle: inputs already driven; advance model and DUT one edge.
    task automatic cycle();
        logic        io;
        logic [15:0] sub;
        int          idx;
        logic        push;
        logic [7:0]  pb;
        #1;
        if (rdy_in && tx_valid && tx_ready) d_drained.push_back(tx_data);
        io   = (mem_a[17:16] == 2'b11);
        sub  = mem_a[15:0];
        idx  = int'(mem_a[16:0]);
        push = 1'b0;
        pb   = 8'h00;
        m_rx_ready = 1'b0;
        if (rdy_in) begin
            if (!mem_wr) begin
                if (!io) begin
                    m_din = m_ram.exists(idx) ? m_ram[idx] : 8'h00;
                end else if (sub == 16'h0000) begin
                    m_din = rx_valid ? rx_data : 8'h00;
                    m_rx_ready = rx_valid;
                end else if (sub == 16'h0004) begin
                    m_din  = m_cyc[7:0];
                    m_snap = m_cyc;
                end else if (sub == 16'h0005) m_din = m_snap[15:8];
                else if (sub == 16'h0006) m_din = m_snap[23:16];
                else if (sub == 16'h0007) m_din = m_snap[31:24];
                else m_din = 8'h00;
            end else begin
                if (!io) m_ram[idx] = mem_dout;
                else if (sub == 16'h0000 && mem_dout != 8'h00) begin
                    push = 1'b1; pb = mem_dout;
                end else if (sub == 16'h0004) begin
                    m_done = 1'b1; push = 1'b1; pb = 8'h00;
                end
            end
            if (tx_ready && m_tx.size() > 0) m_drained.push_back(m_tx.pop_front());
            if (push && m_tx.size() < DEPTH) m_tx.push_back(pb);
            m_full = (m_tx.size() >= DEPTH - 1);
            m_cyc  = m_cyc + 32'd1;
        end
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
        mem_wr = wr; mem_a = a; mem_dout = d;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 32'h0003_0010, 8'h00);
    endtask

    task automatic test_reset();
        n_cmp++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL reset_mem_din got %h want 00", mem_din); end
        n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready got %b want 0", rx_ready); end
        n_cmp++; if (program_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", program_done); end
        n_cmp++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", io_buffer_full); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    endtask

    task automatic test_ram();
        logic [31:0] a;
        logic [7:0]  d;
        bus(1'b1, 32'h0000_0124, 8'h3C);
        bus(1'b1, 32'h0000_0123, 8'hA5);
        bus(1'b0, 32'h0000_0123, 8'h00);
        n_cmp++; if (mem_din !== 8'hA5) begin n_fail++; $display("FAIL ram_a5 got %h want a5", mem_din); end
        bus(1'b0, 32'h0000_0124, 8'h00);
        n_cmp++; if (mem_din !== 8'h3C) begin n_fail++; $display("FAIL ram_3c got %h want 3c", mem_din); end
        for (int i = 0; i < 24; i++) begin
            a = 32'($urandom_range(0, (1 << 17) - 1));
            d = 8'($urandom);
            bus(1'b1, a, d);
            bus(1'b0, a, 8'h00);
            n_cmp++; if (mem_din !== d) begin n_fail++; $display("FAIL ram_rand addr %h got %h want %h", a, mem_din, d); end
        end
        for (int i = 0; i < 8; i++) begin
            a = 32'h0000_0120 + 32'($urandom_range(3, 4));
            bus(1'b0, a, 8'h00);
            n_cmp++; if (mem_din !== m_din) begin n_fail++; $display("FAIL ram_reread addr %h got %h want %h", a, mem_din, m_din); end
        end
    endtask

    task automatic test_tx_filter();
        m_drained.delete(); d_drained.delete();
        tx_ready = 1'b1;
        bus(1'b1, 32'h0003_0000, 8'h48);
        bus(1'b1, 32'h0003_0000, 8'h00);
        bus(1'b1, 32'h0003_0000, 8'h69);
        idle(4);
        n_cmp++; if (d_drained.size() != 2) begin n_fail++; $display("FAIL tx_filter_count got %0d want 2", d_drained.size()); end
        else begin
            n_cmp++; if (d_drained[0] !== 8'h48) begin n_fail++; $display("FAIL tx_filter_b0 got %h want 48", d_drained[0]); end
            n_cmp++; if (d_drained[1] !== 8'h69) begin n_fail++; $display("FAIL tx_filter_b1 got %h want 69", d_drained[1]); end
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] sent [$];
        logic [7:0] b;
        m_drained.delete(); d_drained.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(1, 255));
            sent.push_back(b);
            bus(1'b1, 32'h0003_0000, b);
            n_cmp++; if (io_buffer_full !== m_full) begin n_fail++; $display("FAIL full_flag after %0d got %b want %b", i + 1, io_buffer_full, m_full); end
            if (i == 5) begin
                n_cmp++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL full_at6 got %b want 0", io_buffer_full); end
            end
            if (i == 6) begin
                n_cmp++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL full_at7 got %b want 1", io_buffer_full); end
            end
        end
        // push and pop together while full
        tx_ready = 1'b1;
        b = 8'($urandom_range(1, 255));
        sent.push_back(b);
        bus(1'b1, 32'h0003_0000, b);
        n_cmp++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL full_pushpop got %b want 1", io_buffer_full); end
        idle(12);
        n_cmp++; if (d_drained.size() != 9) begin n_fail++; $display("FAIL drain_count got %0d want 9", d_drained.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (d_drained[i] !== sent[i]) begin n_fail++; $display("FAIL drain_order %0d got %h want %h", i, d_drained[i], sent[i]); end
            end
            n_cmp++; if (d_drained[8] !== sent[9]) begin n_fail++; $display("FAIL drain_last got %h want %h", d_drained[8], sent[9]); end
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", tx_valid); end
        n_cmp++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL drain_full got %b want 0", io_buffer_full); end
    endtask

    task automatic test_counter();
        logic [31:0] exp_word;
        logic [31:0] got;
        for (int i = 0; i < 1000; i++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            bus(1'b0, 32'h0003_0010, 8'h00);
        end
        rdy_in = 1'b1;
        exp_word = m_cyc;
        bus(1'b0, 32'h0003_0004, 8'h00); got[7:0]   = mem_din;
        bus(1'b0, 32'h0003_0005, 8'h00); got[15:8]  = mem_din;
        bus(1'b0, 32'h0003_0006, 8'h00); got[23:16] = mem_din;
        bus(1'b0, 32'h0003_0007, 8'h00); got[31:24] = mem_din;
        n_cmp++; if (got !== exp_word) begin n_fail++; $display("FAIL counter_word got %h want %h", got, exp_word); end
        bus(1'b0, 32'h0003_0001, 8'h00);
        n_cmp++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL io_other_read got %h want 00", mem_din); end
    endtask

    task automatic test_rx();
        logic [7:0] d;
        rx_valid = 1'b1; rx_data = 8'h37;
        bus(1'b0, 32'h0003_0000, 8'h00);
        n_cmp++; if (mem_din !== 8'h37) begin n_fail++; $display("FAIL rx_data got %h want 37", mem_din); end
        n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_strobe got %b want 1", rx_ready); end
        idle(1);
        n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_strobe_end got %b want 0", rx_ready); end
        rx_valid = 1'b0;
        bus(1'b0, 32'h0003_0000, 8'h00);
        n_cmp++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL rx_empty got %h want 00", mem_din); end
        n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_nostrobe got %b want 0", rx_ready); end
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            rx_valid = 1'($urandom_range(0, 1)); rx_data = d;
            bus(1'b0, 32'h0003_0000, 8'h00);
            n_cmp++; if (mem_din !== m_din || rx_ready !== m_rx_ready) begin
                n_fail++; $display("FAIL rx_rand got %h/%b want %h/%b", mem_din, rx_ready, m_din, m_rx_ready);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_done_and_freeze();
        m_drained.delete(); d_drained.delete();
        tx_ready = 1'b0;
        bus(1'b1, 32'h0003_0000, 8'h4F);
        bus(1'b1, 32'h0003_0000, 8'h4B);
        bus(1'b1, 32'h0003_0004, 8'h55);
        n_cmp++; if (program_done !== 1'b1) begin n_fail++; $display("FAIL done_set got %b want 1", program_done); end
        bus(1'b0, 32'h0000_0123, 8'h00);
        rdy_in = 1'b0; tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h11;
        for (int i = 0; i < 5; i++) begin
            bus(i[0], 32'h0003_0000, 8'h77);
            n_cmp++;
            if (mem_din !== m_din || tx_valid !== 1'b1 || tx_data !== m_tx[0] ||
                io_buffer_full !== m_full || program_done !== 1'b1 || rx_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze cyc %0d got din=%h txd=%h full=%b rxr=%b want din=%h txd=%h full=%b rxr=0",
                         i, mem_din, tx_data, io_buffer_full, rx_ready, m_din, m_tx[0], m_full);
            end
        end
        rdy_in = 1'b1; rx_valid = 1'b0;
        idle(6);
        n_cmp++; if (d_drained.size() != 3) begin n_fail++; $display("FAIL term_count got %0d want 3", d_drained.size()); end
        else begin
            n_cmp++; if (d_drained[2] !== 8'h00) begin n_fail++; $display("FAIL term_byte got %h want 00", d_drained[2]); end
            n_cmp++; if (d_drained !== m_drained) begin n_fail++; $display("FAIL term_stream got %p want %p", d_drained, m_drained); end
        end
        n_cmp++; if (program_done !== 1'b1) begin n_fail++; $display("FAIL done_sticky got %b want 1", program_done); end
    endtask

    task automatic test_async_reset();
        tx_ready = 1'b0;
        bus(1'b1, 32'h0003_0000, 8'h5A);
        bus(1'b1, 32'h0003_0000, 8'h5B);
        mem_wr = 1'b0; mem_a = 32'h0000_0123;
        #2 rst_in = 1'b0;
        #1;
        n_cmp++;
        if (mem_din !== 8'h00 || rx_ready !== 1'b0 || program_done !== 1'b0 ||
            io_buffer_full !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got din=%h rxr=%b done=%b full=%b txv=%b want all 0",
                     mem_din, rx_ready, program_done, io_buffer_full, tx_valid);
        end
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        bus(1'b0, 32'h0003_0004, 8'h00);
        n_cmp++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL counter_after_reset got %h want 00", mem_din); end
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; mem_a = 32'h0003_0010; mem_dout = 8'h00;
        mem_wr = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        model_reset();
        @(negedge clk_in);
        test_reset();
        rst_in = 1'b1;
        test_ram();
        test_tx_filter();
        test_fifo_full();
        test_counter();
        test_rx();
        test_done_and_freeze();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
